rtc_timer: RTL and testbench
============================

Name: rtc_timer

Overview:
- Free-running PTP real-time clock. Produces the 48-bit second + 32-bit nanosecond + 16-bit fractional-nanosecond time consumed by the PPS/interval generator and the timestamp units.
- Advances by a programmable tick increment every cycle (frequency trim).
- Supports absolute time load and a handshaked signed offset step (phase correction), issued by the servo/register block.

Parameters:
- FNS_W, 26, fractional-nanosecond bits of the tick increment and internal accumulator (6.26 format).
- SC2NS, 1000000000, nanoseconds per second; ns field rollover value.

Ports:
- rtc_clk  in  1  RTC clock.
- rtc_rst  in  1  asynchronous reset, active-high.
- tick_inc_i  in  32  ns per cycle, 6.26 unsigned; [31:26] integer ns, [25:0] fraction.
- load_i  in  1  single-cycle pulse; load load_sec_i/load_ns_i.
- load_sec_i  in  48  seconds value to load.
- load_ns_i  in  32  nanoseconds value to load; must be < SC2NS.
- adj_req_i  in  1  offset request; level, held until adj_ack_o.
- adj_sign_i  in  1  0: add offset; 1: subtract offset.
- adj_sec_i  in  48  seconds magnitude of offset.
- adj_ns_i  in  32  nanoseconds magnitude of offset; must be < SC2NS.
- adj_slew_i  in  1  slew mode select (RTC_SLEW_EN only).
- slew_step_i  in  6  ns per cycle in slew mode (RTC_SLEW_EN only).
- rtc_std_o  out  80  {seconds[47:0], nanoseconds[31:0]}.
- rtc_fns_o  out  16  fractional ns, accumulator frac[25:10].
- sec_tick_o  out  1  one-cycle pulse on every ns rollover into the next second.
- adj_ack_o  out  1  one-cycle pulse; request finished.
- adj_err_o  out  1  qualifies adj_ack_o; request rejected or aborted.
- adj_busy_o  out  1  high from capture until ack.

Behaviour:
- Reset values:
  - rtc_std_o = 0, rtc_fns_o = 0, accumulator fraction = 0.
  - sec_tick_o, adj_ack_o, adj_err_o, adj_busy_o = 0.
  - FSM in IDLE.
- Normal tick, every cycle:
  - {ns, frac} += tick_inc_i, 58-bit add.
  - If the ns result is >= SC2NS: subtract SC2NS, seconds += 1, sec_tick_o = 1 on the registered update.
  - Outputs are registered; a new tick_inc_i is used from the next cycle.
- Load (load_i):
  - The next registered value is exactly load_sec_i/load_ns_i, with frac = 0 and no tick added that cycle.
  - load_ns_i >= SC2NS is clamped to SC2NS-1.
  - Load has the highest priority and aborts any adjust in progress: adj_ack_o = 1 and adj_err_o = 1 in the following cycle.
- Adjust FSM, states IDLE, CAPT, APPLY, ACK:
  - IDLE -> CAPT when adj_req_i = 1 and no load. Latch sign/sec/ns/slew; set adj_busy_o.
  - CAPT -> APPLY after one cycle. If the latched adj_ns >= SC2NS, go to ACK with adj_err_o = 1 and leave time untouched.
  - APPLY, one cycle, add: t = ns + tick_ns + adj_ns (33-bit); seconds += adj_sec.
  - APPLY, one cycle, subtract: t = ns + tick_ns − adj_ns, signed 34-bit; seconds −= adj_sec.
  - APPLY normalisation: if t >= SC2NS, subtract SC2NS and seconds += 1. If t < 0, add SC2NS and seconds −= 1.
  - Fraction accumulates normally during APPLY.
  - sec_tick_o pulses only on a positive ns carry.
  - APPLY -> ACK: adj_ack_o = 1 for one cycle, adj_busy_o drops.
  - ACK -> IDLE only when adj_req_i = 0. The requester must deassert after ack; no second ack is issued while the request stays high.
- Width and wrap rules:
  - Seconds arithmetic is modulo 2^48, in both directions.
  - ns is always in [0, SC2NS−1] at the outputs.
- Latency: load or adjust is visible on rtc_std_o 1 cycle after load_i, or 2 cycles after adj_req_i is captured.
- Reset asserted mid-adjust returns everything to reset values; no ack is generated.

Optional Feature:
- Macro: RTC_SLEW_EN.
- When defined and adj_slew_i = 1, APPLY is replaced by state SLEW:
  - Each cycle, step = min(slew_step_i, remaining ns).
  - Tick add becomes tick ± step; remaining −= step.
  - adj_sec is applied in the first SLEW cycle.
  - ACK is entered when remaining reaches 0.
  - slew_step_i = 0 is treated as 1.
  - A load aborts the slew with err.
- When not defined: adj_slew_i and slew_step_i are ignored; every adjust is a step.

Decomposition:
- Shared package/defines file holds:
  - FNS_W, SC2NS.
  - The FSM state encodings.
  - The 6.26 tick-format widths, which the PPS/interval block also uses.
- Natural sub-module: rtc_ns_norm. Purely combinational; takes a signed 34-bit ns sum and returns normalised ns plus carry/borrow. It is used in both the tick path and the adjust path.

Test Plan:
- tick_inc = 0x20000000 (8 ns), load sec=5, ns=999_999_992 → next cycle sec=6, ns=0, sec_tick_o=1; following cycle ns=8.
- tick_inc = 0x19999999 (≈6.4 ns), run 5 cycles from ns=0 → ns sequence 6, 12, 19, 25, 31 (truncated 6.26 accumulation; a value of 32 would also be accepted only if it matches the exact 6.26 model), rtc_fns_o consistent with the fractional accumulator.
- At ns=50, tick 8 ns: subtract 100 ns, 0 s → ns=999_999_958, seconds−1, no sec_tick_o, adj_ack_o one pulse, adj_busy_o low after.
- Add offset sec=2, ns=999_999_999 at ns=10 → ns=17, seconds+3, sec_tick_o=1; seconds=2^48−1 plus a carry wraps to 0.
- adj_ns=1_000_000_000 → adj_ack_o with adj_err_o=1, time unchanged apart from normal ticking. load_i during CAPT → load value taken, ack+err next cycle.
- RTC_SLEW_EN: add 20 ns, step 6 → 4 SLEW cycles adding 6, 6, 6, 2 extra ns, then ack. Reset asserted mid-slew → all outputs 0, no ack.

Source files
------------

// File: rtl/rtc_timer_pkg.sv
// Shared constants for the PTP real-time clock: 6.26 tick format, ns rollover, adjust FSM states.
package rtc_timer_pkg;

  localparam int          RTC_FNS_W      = 26;
  localparam int          RTC_TICK_W     = 32;
  localparam int          RTC_TICK_INT_W = RTC_TICK_W - RTC_FNS_W;
  localparam logic [31:0] RTC_SC2NS      = 32'd1_000_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CAPT  = 3'd1,
    ST_APPLY = 3'd2,
    ST_ACK   = 3'd3,
    ST_SLEW  = 3'd4
  } adj_state_e;

endpackage

// File: rtl/rtc_ns_norm.sv
// Folds a signed ns sum (at most one second out of range) back into [0, SC2NS-1].
module rtc_ns_norm
  import rtc_timer_pkg::*;
#(
  parameter logic [31:0] SC2NS = RTC_SC2NS
) (
  input  logic signed [33:0] sum_i,
  output logic        [31:0] ns_o,
  output logic               carry_o,
  output logic               borrow_o
);

  localparam logic signed [33:0] SC2NS_S = {2'b00, SC2NS};

  logic signed [33:0] fold_s;

  // Single correction step is enough: every caller stays within one second of range
  always_comb begin
    carry_o  = 1'b0;
    borrow_o = 1'b0;
    fold_s   = sum_i;
    if (sum_i < 34'sd0) begin
      borrow_o = 1'b1;
      fold_s   = sum_i + SC2NS_S;
    end else if (sum_i >= SC2NS_S) begin
      carry_o = 1'b1;
      fold_s  = sum_i - SC2NS_S;
    end else begin
      fold_s = sum_i;
    end
    ns_o = fold_s[31:0];
  end

endmodule

// File: rtl/rtc_timer.sv
// Free-running PTP clock with frequency trim, absolute load and handshaked offset step.
// Build option RTC_SLEW_EN adds a slewed (per-cycle bounded) offset mode.
module rtc_timer
  import rtc_timer_pkg::*;
#(
  parameter int          FNS_W = RTC_FNS_W,
  parameter logic [31:0] SC2NS = RTC_SC2NS
) (
  input  logic        rtc_clk,
  input  logic        rtc_rst,
  input  logic [31:0] tick_inc_i,
  input  logic        load_i,
  input  logic [47:0] load_sec_i,
  input  logic [31:0] load_ns_i,
  input  logic        adj_req_i,
  input  logic        adj_sign_i,
  input  logic [47:0] adj_sec_i,
  input  logic [31:0] adj_ns_i,
  input  logic        adj_slew_i,
  input  logic [5:0]  slew_step_i,
  output logic [79:0] rtc_std_o,
  output logic [15:0] rtc_fns_o,
  output logic        sec_tick_o,
  output logic        adj_ack_o,
  output logic        adj_err_o,
  output logic        adj_busy_o
);

  adj_state_e         state_q, state_d;
  logic [47:0]        sec_q, sec_d;
  logic [31:0]        ns_q, ns_d;
  logic [FNS_W-1:0]   frac_q, frac_d;
  logic               sec_tick_q, sec_tick_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               adj_sign_q, adj_sign_d;
  logic [47:0]        adj_sec_q, adj_sec_d;
  logic [31:0]        adj_ns_q, adj_ns_d;

  logic [FNS_W:0]     frac_sum_s;
  logic signed [33:0] ns_delta_s;
  logic signed [33:0] sum_s;
  logic [47:0]        sec_base_s;
  logic [31:0]        norm_ns_s;
  logic               carry_s;
  logic               borrow_s;
  logic [31:0]        load_ns_s;

`ifdef RTC_SLEW_EN
  logic               adj_slew_q, adj_slew_d;
  logic               first_q, first_d;
  logic [31:0]        rem_q, rem_d;
  logic [5:0]         step_req_s;
  logic [31:0]        step_s;
`else
  logic               slew_unused_s;
  assign slew_unused_s = ^{adj_slew_i, slew_step_i};
`endif

  // Adjust handshake FSM and selection of the ns/seconds offset applied this cycle
  always_comb begin
    state_d    = state_q;
    adj_sign_d = adj_sign_q;
    adj_sec_d  = adj_sec_q;
    adj_ns_d   = adj_ns_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    ns_delta_s = 34'sd0;
    sec_base_s = sec_q;
`ifdef RTC_SLEW_EN
    adj_slew_d = adj_slew_q;
    first_d    = first_q;
    rem_d      = rem_q;
    step_req_s = (slew_step_i == 6'd0) ? 6'd1 : slew_step_i;
    step_s     = ({26'd0, step_req_s} < rem_q) ? {26'd0, step_req_s} : rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (adj_req_i && !load_i) begin
          state_d    = ST_CAPT;
          adj_sign_d = adj_sign_i;
          adj_sec_d  = adj_sec_i;
          adj_ns_d   = adj_ns_i;
`ifdef RTC_SLEW_EN
          adj_slew_d = adj_slew_i;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPT: begin
        if (load_i) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else if (adj_ns_q >= SC2NS) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          err_d   = 1'b1;
`ifdef RTC_SLEW_EN
        end else if (adj_slew_q) begin
          state_d = ST_SLEW;
          rem_d   = adj_ns_q;
          first_d = 1'b1;
`endif
        end else begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_d = ST_ACK;
        ack_d   = 1'b1;
        if (load_i) begin
          err_d = 1'b1;
        end else if (adj_sign_q) begin
          ns_delta_s = -$signed({2'b00, adj_ns_q});
          sec_base_s = sec_q - adj_sec_q;
        end else begin
          ns_delta_s = $signed({2'b00, adj_ns_q});
          sec_base_s = sec_q + adj_sec_q;
        end
      end
`ifdef RTC_SLEW_EN
      ST_SLEW: begin
        if (load_i) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          first_d = 1'b0;
          rem_d   = rem_q - step_s;
          if (adj_sign_q) begin
            ns_delta_s = -$signed({2'b00, step_s});
            sec_base_s = first_q ? (sec_q - adj_sec_q) : sec_q;
          end else begin
            ns_delta_s = $signed({2'b00, step_s});
            sec_base_s = first_q ? (sec_q + adj_sec_q) : sec_q;
          end
          if (rem_d == 32'd0) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_SLEW;
          end
        end
      end
`endif
      ST_ACK: begin
        if (!adj_req_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_CAPT) || (state_d == ST_APPLY) || (state_d == ST_SLEW);
  end

  // Tick add: {ns, frac} += tick_inc, plus any offset, then normalised into one second
  always_comb begin
    frac_sum_s = {1'b0, frac_q} + {1'b0, tick_inc_i[FNS_W-1:0]};
    sum_s      = $signed({2'b00, ns_q})
               + $signed(34'(tick_inc_i[31:FNS_W]))
               + $signed(34'(frac_sum_s[FNS_W]))
               + ns_delta_s;
  end

  rtc_ns_norm #(
    .SC2NS    (SC2NS)
  ) u_ns_norm (
    .sum_i    (sum_s),
    .ns_o     (norm_ns_s),
    .carry_o  (carry_s),
    .borrow_o (borrow_s)
  );

  // Next time value: load overrides everything, otherwise the normalised tick/offset result
  always_comb begin
    load_ns_s = (load_ns_i >= SC2NS) ? (SC2NS - 32'd1) : load_ns_i;
    if (load_i) begin
      sec_d      = load_sec_i;
      ns_d       = load_ns_s;
      frac_d     = {FNS_W{1'b0}};
      sec_tick_d = 1'b0;
    end else begin
      sec_d      = sec_base_s + {47'd0, carry_s} - {47'd0, borrow_s};
      ns_d       = norm_ns_s;
      frac_d     = frac_sum_s[FNS_W-1:0];
      sec_tick_d = carry_s;
    end
  end

  // State and output registers
  always_ff @(posedge rtc_clk or posedge rtc_rst) begin
    if (rtc_rst) begin
      state_q    <= ST_IDLE;
      sec_q      <= 48'd0;
      ns_q       <= 32'd0;
      frac_q     <= {FNS_W{1'b0}};
      sec_tick_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      adj_sign_q <= 1'b0;
      adj_sec_q  <= 48'd0;
      adj_ns_q   <= 32'd0;
`ifdef RTC_SLEW_EN
      adj_slew_q <= 1'b0;
      first_q    <= 1'b0;
      rem_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      ns_q       <= ns_d;
      frac_q     <= frac_d;
      sec_tick_q <= sec_tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      adj_sign_q <= adj_sign_d;
      adj_sec_q  <= adj_sec_d;
      adj_ns_q   <= adj_ns_d;
`ifdef RTC_SLEW_EN
      adj_slew_q <= adj_slew_d;
      first_q    <= first_d;
      rem_q      <= rem_d;
`endif
    end
  end

  assign rtc_std_o  = {sec_q, ns_q};
  assign rtc_fns_o  = frac_q[FNS_W-1 -: 16];
  assign sec_tick_o = sec_tick_q;
  assign adj_ack_o  = ack_q;
  assign adj_err_o  = err_q;
  assign adj_busy_o = busy_q;

endmodule

// File: tb/tb_rtc_timer.sv
// Directed self-checking bench for rtc_timer (slew checks only when RTC_SLEW_EN is defined).
module tb_rtc_timer;

  logic        rtc_clk = 1'b0;
  logic        rtc_rst;
  logic [31:0] tick_inc_i;
  logic        load_i;
  logic [47:0] load_sec_i;
  logic [31:0] load_ns_i;
  logic        adj_req_i;
  logic        adj_sign_i;
  logic [47:0] adj_sec_i;
  logic [31:0] adj_ns_i;
  logic        adj_slew_i;
  logic [5:0]  slew_step_i;
  logic [79:0] rtc_std_o;
  logic [15:0] rtc_fns_o;
  logic        sec_tick_o;
  logic        adj_ack_o;
  logic        adj_err_o;
  logic        adj_busy_o;

  int checks   = 0;
  int failures = 0;

  rtc_timer dut (
    .rtc_clk     (rtc_clk),
    .rtc_rst     (rtc_rst),
    .tick_inc_i  (tick_inc_i),
    .load_i      (load_i),
    .load_sec_i  (load_sec_i),
    .load_ns_i   (load_ns_i),
    .adj_req_i   (adj_req_i),
    .adj_sign_i  (adj_sign_i),
    .adj_sec_i   (adj_sec_i),
    .adj_ns_i    (adj_ns_i),
    .adj_slew_i  (adj_slew_i),
    .slew_step_i (slew_step_i),
    .rtc_std_o   (rtc_std_o),
    .rtc_fns_o   (rtc_fns_o),
    .sec_tick_o  (sec_tick_o),
    .adj_ack_o   (adj_ack_o),
    .adj_err_o   (adj_err_o),
    .adj_busy_o  (adj_busy_o)
  );

  always #5 rtc_clk = ~rtc_clk;

  task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rtc_clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [47:0] s, input logic [31:0] n);
    load_i     = 1'b1;
    load_sec_i = s;
    load_ns_i  = n;
    step_n(1);
    load_i     = 1'b0;
  endtask

  task automatic start_req(input logic sgn, input logic [47:0] s, input logic [31:0] n);
    adj_req_i  = 1'b1;
    adj_sign_i = sgn;
    adj_sec_i  = s;
    adj_ns_i   = n;
  endtask

  function automatic logic [79:0] tm(input logic [47:0] s, input logic [31:0] n);
    return {s, n};
  endfunction

  logic [57:0] acc;
  int          exp_ns [5] = '{6, 12, 19, 25, 31};

  initial begin
    rtc_rst     = 1'b1;
    tick_inc_i  = 32'd0;
    load_i      = 1'b0;
    load_sec_i  = 48'd0;
    load_ns_i   = 32'd0;
    adj_req_i   = 1'b0;
    adj_sign_i  = 1'b0;
    adj_sec_i   = 48'd0;
    adj_ns_i    = 32'd0;
    adj_slew_i  = 1'b0;
    slew_step_i = 6'd0;
    step_n(2);
    check_val("rst_std", rtc_std_o, tm(48'd0, 32'd0));
    check_val("rst_fns", rtc_fns_o, 16'd0);
    check_val("rst_tick", sec_tick_o, 1'b0);
    check_val("rst_ack", adj_ack_o, 1'b0);
    check_val("rst_err", adj_err_o, 1'b0);
    check_val("rst_busy", adj_busy_o, 1'b0);
    rtc_rst = 1'b0;

    // Load then ns rollover with an 8 ns tick
    tick_inc_i = 32'h2000_0000;
    do_load(48'd5, 32'd999_999_992);
    check_val("load_val", rtc_std_o, tm(48'd5, 32'd999_999_992));
    check_val("load_fns", rtc_fns_o, 16'd0);
    step_n(1);
    check_val("roll_std", rtc_std_o, tm(48'd6, 32'd0));
    check_val("roll_tick", sec_tick_o, 1'b1);
    step_n(1);
    check_val("roll_next", rtc_std_o, tm(48'd6, 32'd8));
    check_val("roll_tick_off", sec_tick_o, 1'b0);

    // Fractional 6.26 accumulation
    tick_inc_i = 32'h1999_9999;
    do_load(48'd0, 32'd0);
    acc = 58'd0;
    for (int k = 0; k < 5; k++) begin
      step_n(1);
      acc = acc + 58'h1999_9999;
      check_val("frac_ns", rtc_std_o, tm(48'd0, exp_ns[k]));
      check_val("frac_fns", rtc_fns_o, acc[25:10]);
    end

    // Subtract 100 ns with ns = 50 in the APPLY cycle
    tick_inc_i = 32'h2000_0000;
    do_load(48'd10, 32'd34);
    start_req(1'b1, 48'd0, 32'd100);
    step_n(1);
    check_val("sub_busy_capt", adj_busy_o, 1'b1);
    check_val("sub_capt_std", rtc_std_o, tm(48'd10, 32'd42));
    step_n(1);
    check_val("sub_pre_std", rtc_std_o, tm(48'd10, 32'd50));
    check_val("sub_ack_early", adj_ack_o, 1'b0);
    step_n(1);
    check_val("sub_std", rtc_std_o, tm(48'd9, 32'd999_999_958));
    check_val("sub_tick", sec_tick_o, 1'b0);
    check_val("sub_ack", adj_ack_o, 1'b1);
    check_val("sub_err", adj_err_o, 1'b0);
    check_val("sub_busy", adj_busy_o, 1'b0);
    step_n(1);
    check_val("sub_no_reack", adj_ack_o, 1'b0);
    check_val("sub_next_std", rtc_std_o, tm(48'd9, 32'd999_999_966));
    adj_req_i = 1'b0;
    step_n(1);
    check_val("sub_idle_ack", adj_ack_o, 1'b0);
    check_val("sub_idle_busy", adj_busy_o, 1'b0);

    // Add 2 s + 999_999_999 ns at ns = 10
    tick_inc_i = 32'd0;
    do_load(48'd100, 32'd10);
    start_req(1'b0, 48'd2, 32'd999_999_999);
    step_n(2);
    check_val("add_pre_std", rtc_std_o, tm(48'd100, 32'd10));
    tick_inc_i = 32'h2000_0000;
    step_n(1);
    check_val("add_std", rtc_std_o, tm(48'd103, 32'd17));
    check_val("add_tick", sec_tick_o, 1'b1);
    check_val("add_ack", adj_ack_o, 1'b1);
    adj_req_i = 1'b0;
    step_n(1);
    check_val("add_next_std", rtc_std_o, tm(48'd103, 32'd25));
    check_val("add_tick_off", sec_tick_o, 1'b0);

    // Seconds wrap in both directions
    do_load(48'hFFFF_FFFF_FFFF, 32'd999_999_992);
    step_n(1);
    check_val("wrap_up", rtc_std_o, tm(48'd0, 32'd0));
    check_val("wrap_up_tick", sec_tick_o, 1'b1);
    tick_inc_i = 32'd0;
    do_load(48'd0, 32'd500);
    start_req(1'b1, 48'd1, 32'd0);
    step_n(3);
    check_val("wrap_down", rtc_std_o, tm(48'hFFFF_FFFF_FFFF, 32'd500));
    check_val("wrap_down_ack", adj_ack_o, 1'b1);
    adj_req_i = 1'b0;
    step_n(1);

    // Out-of-range adj_ns rejected, time keeps ticking
    tick_inc_i = 32'h2000_0000;
    do_load(48'd7, 32'd100);
    start_req(1'b0, 48'd3, 32'd1_000_000_000);
    step_n(2);
    check_val("bad_std", rtc_std_o, tm(48'd7, 32'd116));
    check_val("bad_ack", adj_ack_o, 1'b1);
    check_val("bad_err", adj_err_o, 1'b1);
    check_val("bad_busy", adj_busy_o, 1'b0);
    adj_req_i = 1'b0;
    step_n(1);
    check_val("bad_err_off", adj_err_o, 1'b0);
    check_val("bad_next_std", rtc_std_o, tm(48'd7, 32'd124));

    // Load during CAPT aborts the adjust; load_ns clamps
    do_load(48'd1, 32'd0);
    start_req(1'b0, 48'd5, 32'd5);
    step_n(1);
    check_val("abort_busy", adj_busy_o, 1'b1);
    load_i     = 1'b1;
    load_sec_i = 48'd50;
    load_ns_i  = 32'd2_000_000_000;
    step_n(1);
    load_i    = 1'b0;
    adj_req_i = 1'b0;
    check_val("abort_std", rtc_std_o, tm(48'd50, 32'd999_999_999));
    check_val("abort_ack", adj_ack_o, 1'b1);
    check_val("abort_err", adj_err_o, 1'b1);
    check_val("abort_busy_off", adj_busy_o, 1'b0);
    step_n(1);
    check_val("abort_next_std", rtc_std_o, tm(48'd51, 32'd7));
    check_val("abort_ack_off", adj_ack_o, 1'b0);

    // Reset in the middle of an adjust
    start_req(1'b0, 48'd1, 32'd1);
    step_n(1);
    rtc_rst = 1'b1;
    #2;
    check_val("mid_rst_std", rtc_std_o, tm(48'd0, 32'd0));
    check_val("mid_rst_busy", adj_busy_o, 1'b0);
    adj_req_i  = 1'b0;
    tick_inc_i = 32'd0;
    step_n(1);
    rtc_rst = 1'b0;
    step_n(3);
    check_val("mid_rst_ack", adj_ack_o, 1'b0);
    check_val("mid_rst_hold", rtc_std_o, tm(48'd0, 32'd0));

`ifdef RTC_SLEW_EN
    // Slewed add of 1 s + 20 ns at 6 ns per cycle
    tick_inc_i  = 32'h2000_0000;
    do_load(48'd0, 32'd0);
    adj_slew_i  = 1'b1;
    slew_step_i = 6'd6;
    start_req(1'b0, 48'd1, 32'd20);
    step_n(2);
    check_val("slew_pre", rtc_std_o, tm(48'd0, 32'd16));
    step_n(1);
    check_val("slew_1", rtc_std_o, tm(48'd1, 32'd30));
    check_val("slew_busy", adj_busy_o, 1'b1);
    check_val("slew_ack_early", adj_ack_o, 1'b0);
    step_n(1);
    check_val("slew_2", rtc_std_o, tm(48'd1, 32'd44));
    step_n(1);
    check_val("slew_3", rtc_std_o, tm(48'd1, 32'd58));
    step_n(1);
    check_val("slew_4", rtc_std_o, tm(48'd1, 32'd68));
    check_val("slew_ack", adj_ack_o, 1'b1);
    check_val("slew_busy_off", adj_busy_o, 1'b0);
    adj_req_i = 1'b0;
    step_n(1);

    // Reset during a slew
    do_load(48'd0, 32'd0);
    start_req(1'b0, 48'd0, 32'd60);
    step_n(3);
    rtc_rst = 1'b1;
    #2;
    check_val("slew_rst_std", rtc_std_o, tm(48'd0, 32'd0));
    check_val("slew_rst_busy", adj_busy_o, 1'b0);
    adj_req_i  = 1'b0;
    adj_slew_i = 1'b0;
    step_n(1);
    rtc_rst = 1'b0;
    step_n(2);
    check_val("slew_rst_ack", adj_ack_o, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
